fatigue_judge: RTL and testbench



---
 rtl/fatigue_judge_pkg.sv | 26 ++
 rtl/eye_closed_cmp.sv | 21 ++
 rtl/fatigue_judge.sv | 178 +++++++++++++++++
 tb/tb_fatigue_judge.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fatigue_judge_pkg.sv
// Shared definitions for the fatigue decision stage: FSM encoding,
// default thresholds and a small saturating-counter helper.
package fatigue_judge_pkg;

    // Decision FSM encoding.
    typedef enum logic [1:0] {
        FJ_IDLE = 2'd0,
        FJ_ARM  = 2'd1,
        FJ_RUN  = 2'd2
    } fj_state_t;

    // Default thresholds.
    localparam int unsigned DEF_WIN_FRAMES = 60;
    localparam int unsigned DEF_CLOSED_NUM = 4;
    localparam int unsigned DEF_PERCLOS_TH = 24;
    localparam int unsigned DEF_LONG_CLOSE = 45;
    localparam int unsigned DEF_BLINK_MAX  = 8;
    localparam int unsigned DEF_SAMPLE_X   = 700;
    localparam int unsigned DEF_SAMPLE_Y   = 480;

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/eye_closed_cmp.sv
// Per-eye open/closed classifier by aspect ratio.
// An eye is closed when its width is zero or when high*16 < wide*CLOSED_NUM.
// Both sides are formed at 16 bits so no product is truncated.
module eye_closed_cmp
    import fatigue_judge_pkg::*;
#(
    parameter int unsigned CLOSED_NUM = DEF_CLOSED_NUM
) (
    input  logic [10:0] high,
    input  logic [10:0] wide,
    output logic        closed
);

    logic [15:0] high_scaled;
    logic [15:0] wide_scaled;

    assign high_scaled = {1'b0, high, 4'b0000};
    assign wide_scaled = 16'(wide) * 16'(CLOSED_NUM);
    assign closed      = (wide == 11'd0) || (high_scaled < wide_scaled);

endmodule

// File: rtl/fatigue_judge.sv
// Per-frame fatigue decision stage. Samples the tracked eye sizes once per
// frame at a fixed pixel position, classifies the frame as open/closed, and
// accumulates PERCLOS and blink counts over a sliding window of frames.
// Drives a latched alarm on high PERCLOS or on a long continuous closure.
module fatigue_judge
    import fatigue_judge_pkg::*;
#(
    parameter int unsigned WIN_FRAMES = DEF_WIN_FRAMES,
    parameter int unsigned CLOSED_NUM = DEF_CLOSED_NUM,
    parameter int unsigned PERCLOS_TH = DEF_PERCLOS_TH,
    parameter int unsigned LONG_CLOSE = DEF_LONG_CLOSE,
    parameter int unsigned BLINK_MAX  = DEF_BLINK_MAX,
    parameter int unsigned SAMPLE_X   = DEF_SAMPLE_X,
    parameter int unsigned SAMPLE_Y   = DEF_SAMPLE_Y
) (
    input  logic        module_clk,
    input  logic        module_rst_n,
    input  logic [10:0] lcd_pixel_xpos,
    input  logic [10:0] lcd_pixel_ypos,
    input  logic [10:0] eye_lock,
    input  logic [10:0] eye1_high_trk,
    input  logic [10:0] eye1_wide_trk,
    input  logic [10:0] eye2_high_trk,
    input  logic [10:0] eye2_wide_trk,
    output logic        frame_valid,
    output logic [1:0]  eye_state,
    output logic [7:0]  closed_frames,
    output logic [7:0]  blink_cnt,
    output logic        fatigue_alarm
);

    localparam logic [10:0] SX          = 11'(SAMPLE_X);
    localparam logic [10:0] SY          = 11'(SAMPLE_Y);
    localparam logic [7:0]  WIN_LAST    = 8'(WIN_FRAMES - 1);
    localparam logic [7:0]  PERCLOS_TH8 = 8'(PERCLOS_TH);
    localparam logic [7:0]  LONG_TH8    = 8'(LONG_CLOSE);
    localparam logic [7:0]  BLINK_MAX8  = 8'(BLINK_MAX);

    fj_state_t   state;
    logic        match;
    logic        match_d;
    logic        tick;
    logic        tracking;
    logic        eye1_closed;
    logic        eye2_closed;
    logic        frame_closed;

    logic [7:0]  win_cnt;
    logic [7:0]  closed_acc;
    logic [7:0]  blink_acc;
    logic [7:0]  run_len;
    logic        long_seen;

    logic [7:0]  run_len_nx;
    logic [7:0]  blink_acc_nx;
    logic [7:0]  closed_acc_nx;
    logic        long_now;
    logic        win_end;
    logic        perclos_hit;

    assign match    = (lcd_pixel_xpos == SX) && (lcd_pixel_ypos == SY);
    assign tick     = match & ~match_d;
    assign tracking = (eye_lock == 11'd0);

    eye_closed_cmp #(.CLOSED_NUM(CLOSED_NUM)) u_eye1_cmp (
        .high   (eye1_high_trk),
        .wide   (eye1_wide_trk),
        .closed (eye1_closed)
    );

    eye_closed_cmp #(.CLOSED_NUM(CLOSED_NUM)) u_eye2_cmp (
        .high   (eye2_high_trk),
        .wide   (eye2_wide_trk),
        .closed (eye2_closed)
    );

    assign frame_closed = eye1_closed & eye2_closed;

    // Delay the position match so a held sample point yields a single tick.
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            match_d <= 1'b0;
        end else begin
            match_d <= match;
        end
    end

    // Counter values after accounting for the current frame.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        run_len_nx    = 8'd0;
        blink_acc_nx  = blink_acc;
        closed_acc_nx = closed_acc + {7'd0, frame_closed};
        if (frame_closed) begin
            run_len_nx = sat_inc8(run_len);
        end else if ((run_len != 8'd0) && (run_len <= BLINK_MAX8)) begin
            blink_acc_nx = sat_inc8(blink_acc);
        end
        long_now    = (run_len_nx >= LONG_TH8);
        win_end     = (win_cnt == WIN_LAST);
        perclos_hit = (closed_acc_nx >= PERCLOS_TH8);
    end

    // Lock FSM, per-frame evaluation, window accounting and alarm latch.
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            state         <= FJ_IDLE;
            frame_valid   <= 1'b0;
            eye_state     <= 2'b00;
            closed_frames <= 8'd0;
            blink_cnt     <= 8'd0;
            fatigue_alarm <= 1'b0;
            win_cnt       <= 8'd0;
            closed_acc    <= 8'd0;
            blink_acc     <= 8'd0;
            run_len       <= 8'd0;
            long_seen     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values, independent of statement order.
            frame_valid <= 1'b0;
            if (!tracking) begin
                // Losing lock wins over a tick; published results are kept.
                state         <= FJ_IDLE;
                fatigue_alarm <= 1'b0;
                win_cnt       <= 8'd0;
                closed_acc    <= 8'd0;
                blink_acc     <= 8'd0;
                run_len       <= 8'd0;
                long_seen     <= 1'b0;
            end else begin
                case (state)
                    FJ_IDLE: begin
                        state <= FJ_ARM;
                    end
                    FJ_ARM: begin
                        // First tick after lock carries stale tracker data.
                        if (tick) begin
                            state <= FJ_RUN;
                        end
                    end
                    FJ_RUN: begin
                        if (tick) begin
                            frame_valid <= 1'b1;
                            eye_state   <= {eye2_closed, eye1_closed};
                            run_len     <= run_len_nx;
                            if (win_end) begin
                                closed_frames <= closed_acc_nx;
                                blink_cnt     <= blink_acc_nx;
                                win_cnt       <= 8'd0;
                                closed_acc    <= 8'd0;
                                blink_acc     <= 8'd0;
                                long_seen     <= 1'b0;
                                // Set wins; a clear needs a window with no long closure.
                                if (perclos_hit || long_now) begin
                                    fatigue_alarm <= 1'b1;
                                end else if (!long_seen) begin
                                    fatigue_alarm <= 1'b0;
                                end
                            end else begin
                                win_cnt    <= win_cnt + 8'd1;
                                closed_acc <= closed_acc_nx;
                                blink_acc  <= blink_acc_nx;
                                if (long_now) begin
                                    long_seen     <= 1'b1;
                                    fatigue_alarm <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= FJ_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fatigue_judge.sv
// Directed bench for fatigue_judge with default parameters
// (window 60, PERCLOS 24, long closure 45, blink max 8, ratio 4/16).
module tb_fatigue_judge;

    logic        module_clk;
    logic        module_rst_n;
    logic [10:0] lcd_pixel_xpos;
    logic [10:0] lcd_pixel_ypos;
    logic [10:0] eye_lock;
    logic [10:0] eye1_high_trk;
    logic [10:0] eye1_wide_trk;
    logic [10:0] eye2_high_trk;
    logic [10:0] eye2_wide_trk;
    logic        frame_valid;
    logic [1:0]  eye_state;
    logic [7:0]  closed_frames;
    logic [7:0]  blink_cnt;
    logic        fatigue_alarm;

    int n_vec = 0;
    int n_bad = 0;
    int fv_count = 0;
    int fv_base;

    fatigue_judge dut (
        .module_clk     (module_clk),
        .module_rst_n   (module_rst_n),
        .lcd_pixel_xpos (lcd_pixel_xpos),
        .lcd_pixel_ypos (lcd_pixel_ypos),
        .eye_lock       (eye_lock),
        .eye1_high_trk  (eye1_high_trk),
        .eye1_wide_trk  (eye1_wide_trk),
        .eye2_high_trk  (eye2_high_trk),
        .eye2_wide_trk  (eye2_wide_trk),
        .frame_valid    (frame_valid),
        .eye_state      (eye_state),
        .closed_frames  (closed_frames),
        .blink_cnt      (blink_cnt),
        .fatigue_alarm  (fatigue_alarm)
    );

    initial module_clk = 1'b0;
    always #5 module_clk = ~module_clk;

    // Count frame_valid pulses mid-cycle, away from the active edge.
    always @(negedge module_clk) begin
        if (frame_valid) fv_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One frame: present eye sizes, hold the sample position, then leave it.
    task automatic frame(input logic [10:0] h1, input logic [10:0] w1,
                         input logic [10:0] h2, input logic [10:0] w2,
                         input int hold);
        @(negedge module_clk);
        eye1_high_trk  = h1;
        eye1_wide_trk  = w1;
        eye2_high_trk  = h2;
        eye2_wide_trk  = w2;
        lcd_pixel_xpos = 11'd700;
        lcd_pixel_ypos = 11'd480;
        repeat (hold) @(negedge module_clk);
        lcd_pixel_xpos = 11'd0;
        lcd_pixel_ypos = 11'd0;
        #1;
    endtask

    task automatic open_frames(input int n);
        for (int i = 0; i < n; i++) frame(11'd20, 11'd40, 11'd20, 11'd40, 1);
    endtask

    task automatic closed_frames_run(input int n);
        for (int i = 0; i < n; i++) frame(11'd5, 11'd40, 11'd5, 11'd40, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got 0, expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        module_rst_n   = 1'b0;
        eye_lock       = 11'd0;
        lcd_pixel_xpos = 11'd0;
        lcd_pixel_ypos = 11'd0;
        eye1_high_trk  = 11'd20;
        eye1_wide_trk  = 11'd40;
        eye2_high_trk  = 11'd20;
        eye2_wide_trk  = 11'd40;
        #1;
        check("rst_frame_valid", frame_valid, 0);
        check("rst_eye_state", eye_state, 0);
        check("rst_closed_frames", closed_frames, 0);
        check("rst_blink_cnt", blink_cnt, 0);
        check("rst_alarm", fatigue_alarm, 0);
        repeat (2) @(negedge module_clk);
        module_rst_n = 1'b1;

        // Window 1: ARM frame discarded, then 60 open frames.
        open_frames(1);
        check("arm_discard_fv", fv_count, 0);
        open_frames(60);
        check("w1_fv_count", fv_count, 60);
        check("w1_eye_state", eye_state, 0);
        check("w1_closed_frames", closed_frames, 0);
        check("w1_blink_cnt", blink_cnt, 0);
        check("w1_alarm", fatigue_alarm, 0);

        // Window 2: eight runs of 3 closed + 1 open, then 28 open.
        for (int r = 0; r < 8; r++) begin
            closed_frames_run(3);
            open_frames(1);
        end
        open_frames(27);
        check("w2_alarm_before_end", fatigue_alarm, 0);
        open_frames(1);
        check("w2_closed_frames", closed_frames, 24);
        check("w2_blink_cnt", blink_cnt, 8);
        check("w2_alarm", fatigue_alarm, 1);

        // Window 3: all open, alarm clears at window end.
        open_frames(60);
        check("w3_closed_frames", closed_frames, 0);
        check("w3_alarm", fatigue_alarm, 0);

        // Window 4: 38 open then 22 closed; closure continues into window 5.
        open_frames(38);
        closed_frames_run(22);
        check("w4_closed_frames", closed_frames, 22);
        check("w4_blink_cnt", blink_cnt, 0);
        check("w4_alarm", fatigue_alarm, 0);
        closed_frames_run(22);
        check("long_44_alarm", fatigue_alarm, 0);
        closed_frames_run(1);
        check("long_45_alarm", fatigue_alarm, 1);
        open_frames(37);
        check("w5_closed_frames", closed_frames, 23);
        check("w5_blink_cnt", blink_cnt, 0);
        check("w5_alarm_held", fatigue_alarm, 1);

        // Window 6: open, long_seen was cleared so the alarm clears.
        open_frames(60);
        check("w6_alarm", fatigue_alarm, 0);

        // Eye1 closed, eye2 open for a full window.
        for (int i = 0; i < 60; i++) frame(11'd5, 11'd40, 11'd20, 11'd40, 1);
        check("one_eye_state", eye_state, 1);
        check("one_eye_closed_frames", closed_frames, 0);
        check("one_eye_alarm", fatigue_alarm, 0);

        // Ratio boundaries.
        frame(11'd20, 11'd0, 11'd20, 11'd40, 1);
        check("wide_zero_state", eye_state, 1);
        frame(11'd10, 11'd40, 11'd10, 11'd40, 1);
        check("ratio_equal_state", eye_state, 0);
        frame(11'd9, 11'd40, 11'd9, 11'd40, 1);
        check("ratio_below_state", eye_state, 3);
        frame(11'd1024, 11'd2047, 11'd1024, 11'd2047, 1);
        check("wide_no_trunc_state", eye_state, 0);
        frame(11'd0, 11'd2047, 11'd0, 11'd2047, 1);
        check("high_zero_state", eye_state, 3);

        // Raise alarm by long closure, then drop lock on a tick cycle.
        closed_frames_run(45);
        check("pre_lock_alarm", fatigue_alarm, 1);
        fv_base = fv_count;
        @(negedge module_clk);
        eye_lock       = 11'd1;
        eye1_high_trk  = 11'd20;
        eye2_high_trk  = 11'd20;
        eye1_wide_trk  = 11'd40;
        eye2_wide_trk  = 11'd40;
        lcd_pixel_xpos = 11'd700;
        lcd_pixel_ypos = 11'd480;
        @(negedge module_clk);
        #1;
        check("lock_fv", frame_valid, 0);
        check("lock_alarm", fatigue_alarm, 0);
        check("lock_eye_state_kept", eye_state, 3);
        lcd_pixel_xpos = 11'd0;
        lcd_pixel_ypos = 11'd0;
        @(negedge module_clk);
        eye_lock = 11'd0;
        open_frames(1);
        check("relock_discard_fv", fv_count - fv_base, 0);
        check("relock_discard_state", eye_state, 3);
        open_frames(1);
        check("relock_first_fv", fv_count - fv_base, 1);
        check("relock_first_state", eye_state, 0);

        // Sample position held for 5 cycles gives one frame_valid.
        fv_base = fv_count;
        frame(11'd20, 11'd40, 11'd20, 11'd40, 5);
        check("hold5_fv_count", fv_count - fv_base, 1);
        check("hold5_fv_low", frame_valid, 0);

        // Asynchronous reset mid-window.
        closed_frames_run(1);
        check("pre_reset_state", eye_state, 3);
        #2;
        module_rst_n = 1'b0;
        #1;
        check("async_rst_state", eye_state, 0);
        check("async_rst_fv", frame_valid, 0);
        check("async_rst_alarm", fatigue_alarm, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
